// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The slave side is the subtractor; the master side is whatever feeds and drains it.
interface serial_subtractor_if #(
   parameter int WIDTH = 3
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] d;
   logic             bout;
   logic             ovf;

   modport master (
      output start_valid, a, b, bin, res_ready,
      input  start_ready, res_valid, d, bout, ovf
   );

   modport slave (
      input  start_valid, a, b, bin, res_ready,
      output start_ready, res_valid, d, bout, ovf
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor D = A - B - Bin, one bit per clock,
// with valid/ready handshakes on both the operand and the result side.
module serial_subtractor #(
   parameter int WIDTH = 3
) (
   input logic               clk,
   input logic               rst_n,
   serial_subtractor_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] aSh;
   logic [WIDTH-1:0] bSh;
   logic [WIDTH-1:0] resSh;
   logic             brw;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] dReg;
   logic             boutReg;
   logic             ovfReg;
   logic             startReady;
   logic             resValid;

   logic             x;
   logic             y;
   logic             c;
   logic             diff;
   logic             brwNext;
   logic [WIDTH-1:0] diffMsb;
   logic [WIDTH-1:0] resNext;
   logic             lastBit;

   // Full-subtractor cell on the operand LSBs; the difference bit enters the result from the top.
   always_comb begin
      x       = aSh[0];
      y       = bSh[0];
      c       = brw;
      diff    = x ^ y ^ c;
      brwNext = (~x & y) | (~(x ^ y) & c);
      diffMsb = '0;
      diffMsb[WIDTH-1] = diff;
      resNext = (resSh >> 1) | diffMsb;
      lastBit = (cnt == LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         aSh        <= '0;
         bSh        <= '0;
         resSh      <= '0;
         brw        <= 1'b0;
         cnt        <= '0;
         dReg       <= '0;
         boutReg    <= 1'b0;
         ovfReg     <= 1'b0;
         startReady <= 1'b1;
         resValid   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_valid && startReady) begin
                  aSh        <= bus.a;
                  bSh        <= bus.b;
                  brw        <= bus.bin;
                  cnt        <= '0;
                  startReady <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               aSh   <= aSh >> 1;
               bSh   <= bSh >> 1;
               resSh <= resNext;
               brw   <= brwNext;
               cnt   <= cnt + CW'(1);
               // On the MSB cycle, c is the borrow into the sign bit.
               if (lastBit) begin
                  dReg     <= resNext;
                  boutReg  <= brwNext;
                  ovfReg   <= c ^ brwNext;
                  resValid <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (bus.res_ready) begin
                  resValid   <= 1'b0;
                  startReady <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               resValid   <= 1'b0;
               startReady <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

   assign bus.start_ready = startReady;
   assign bus.res_valid   = resValid;
   assign bus.d           = dReg;
   assign bus.bout        = boutReg;
   assign bus.ovf         = ovfReg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=3) with a queue-based scoreboard.
module tb_serial_subtractor;

   localparam int W = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int passCnt = 0;
   int totalCnt = 0;
   int accepted = 0;
   int results = 0;
   logic [W+1:0] expQ[$];

   // Independent reference: integer difference for d/bout, signed range test for ovf.
   function automatic logic [W+1:0] model(input int a, input int b, input int bin);
      int diff;
      int sa;
      int sb;
      int sd;
      logic [W-1:0] dd;
      logic bo;
      logic ov;
      diff = a - b - bin;
      sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
      sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
      sd = sa - sb - bin;
      dd = diff[W-1:0];
      bo = (diff < 0);
      ov = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
      return {dd, bo, ov};
   endfunction

   task automatic drive_op(input int a, input int b, input int bin, input bit push,
                           output bit ok);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.start_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = bus.start_ready;
      if (ok) begin
         bus.a = W'(a);
         bus.b = W'(b);
         bus.bin = bin[0];
         bus.start_valid = 1'b1;
         if (push) begin
            expQ.push_back(model(a, b, bin));
            accepted++;
         end
         @(posedge clk);
         @(negedge clk);
         bus.start_valid = 1'b0;
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      totalCnt++;
      if ({bus.start_ready, bus.res_valid, bus.d, bus.bout, bus.ovf} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
         $display("FAIL reset_state: got sr=%b rv=%b d=%0d bout=%b ovf=%b, required sr=1 rv=0 d=0 bout=0 ovf=0",
                  bus.start_ready, bus.res_valid, bus.d, bus.bout, bus.ovf);
      end else passCnt++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int av[5] = '{5, 3, 3, 0, 4};
      int bv[5] = '{3, 5, 4, 0, 1};
      int cv[5] = '{0, 0, 0, 1, 0};
      logic [W+1:0] exp;
      logic [W+1:0] got;
      bit ok;
      int n;
      bus.res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive_op(av[i], bv[i], cv[i], 1'b1, ok);
         totalCnt++;
         if (!ok) $display("FAIL basic_accept[%0d]: start_ready never 1, required 1", i);
         else passCnt++;
         n = 0;
         while (!bus.res_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         totalCnt++;
         if (n !== W) $display("FAIL basic_latency[%0d]: got %0d cycles, required %0d", i, n, W);
         else passCnt++;
         got = {bus.d, bus.bout, bus.ovf};
         exp = (expQ.size() > 0) ? expQ.pop_front() : 'x;
         results++;
         totalCnt++;
         if (got !== exp)
            $display("FAIL basic_result[%0d] a=%0d b=%0d bin=%0d: got d=%0d bout=%b ovf=%b, required d=%0d bout=%b ovf=%b",
                     i, av[i], bv[i], cv[i], got[W+1:2], got[1], got[0], exp[W+1:2], exp[1], exp[0]);
         else passCnt++;
         @(negedge clk);
         totalCnt++;
         if ({bus.res_valid, bus.start_ready} !== 2'b01)
            $display("FAIL basic_handoff[%0d]: got rv=%b sr=%b, required rv=0 sr=1", i, bus.res_valid, bus.start_ready);
         else passCnt++;
      end
   endtask

   task automatic test_backpressure;
      logic [W+1:0] held;
      logic [W+1:0] exp;
      bit ok;
      int n;
      bus.res_ready = 1'b0;
      drive_op(5, 3, 0, 1'b1, ok);
      n = 0;
      while (!bus.res_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      held = {bus.d, bus.bout, bus.ovf};
      for (int i = 0; i < 5; i++) begin
         bus.start_valid = i[0];
         bus.a = W'(i + 1);
         bus.b = W'(7 - i);
         @(negedge clk);
         totalCnt++;
         if ({bus.d, bus.bout, bus.ovf, bus.res_valid, bus.start_ready} !== {held, 1'b1, 1'b0})
            $display("FAIL bp_hold[%0d]: got d=%0d bout=%b ovf=%b rv=%b sr=%b, required d=%0d bout=%b ovf=%b rv=1 sr=0",
                     i, bus.d, bus.bout, bus.ovf, bus.res_valid, bus.start_ready, held[W+1:2], held[1], held[0]);
         else passCnt++;
      end
      bus.start_valid = 1'b0;
      exp = (expQ.size() > 0) ? expQ.pop_front() : 'x;
      results++;
      totalCnt++;
      if (held !== exp)
         $display("FAIL bp_result: got d=%0d bout=%b ovf=%b, required d=%0d bout=%b ovf=%b",
                  held[W+1:2], held[1], held[0], exp[W+1:2], exp[1], exp[0]);
      else passCnt++;
      bus.res_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         totalCnt++;
         if ({bus.res_valid, bus.start_ready} !== 2'b01)
            $display("FAIL bp_no_accept[%0d]: got rv=%b sr=%b, required rv=0 sr=1", i, bus.res_valid, bus.start_ready);
         else passCnt++;
      end
   endtask

   task automatic test_reset_midrun;
      logic [W+1:0] exp;
      bit ok;
      int n;
      bus.res_ready = 1'b1;
      drive_op(7, 1, 0, 1'b0, ok);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      totalCnt++;
      if ({bus.start_ready, bus.res_valid, bus.d, bus.bout, bus.ovf} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0})
         $display("FAIL midrun_reset: got sr=%b rv=%b d=%0d bout=%b ovf=%b, required sr=1 rv=0 d=0 bout=0 ovf=0",
                  bus.start_ready, bus.res_valid, bus.d, bus.bout, bus.ovf);
      else passCnt++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         totalCnt++;
         if (bus.res_valid !== 1'b0) $display("FAIL midrun_discard[%0d]: got rv=%b, required 0", i, bus.res_valid);
         else passCnt++;
      end
      drive_op(6, 2, 0, 1'b1, ok);
      n = 0;
      while (!bus.res_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      exp = (expQ.size() > 0) ? expQ.pop_front() : 'x;
      results++;
      totalCnt++;
      if ({bus.d, bus.bout, bus.ovf} !== exp)
         $display("FAIL midrun_after: got d=%0d bout=%b ovf=%b, required d=%0d bout=%b ovf=%b",
                  bus.d, bus.bout, bus.ovf, exp[W+1:2], exp[1], exp[0]);
      else passCnt++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [W+1:0] exp;
      bit ok;
      bit done;
      int n;
      for (int a = 0; a < (1 << W); a++) begin
         for (int b = 0; b < (1 << W); b++) begin
            for (int c = 0; c < 2; c++) begin
               drive_op(a, b, c, 1'b1, ok);
               if (!ok) begin
                  totalCnt++;
                  $display("FAIL b2b_accept a=%0d b=%0d bin=%0d: start_ready stuck 0, required 1", a, b, c);
                  continue;
               end
               done = 1'b0;
               n = 0;
               while (!done && n < 200) begin
                  if (bus.res_valid && ($urandom_range(0, 1) == 1)) begin
                     exp = (expQ.size() > 0) ? expQ.pop_front() : 'x;
                     results++;
                     totalCnt++;
                     if ({bus.d, bus.bout, bus.ovf} !== exp)
                        $display("FAIL b2b_result a=%0d b=%0d bin=%0d: got d=%0d bout=%b ovf=%b, required d=%0d bout=%b ovf=%b",
                                 a, b, c, bus.d, bus.bout, bus.ovf, exp[W+1:2], exp[1], exp[0]);
                     else passCnt++;
                     bus.res_ready = 1'b1;
                     @(posedge clk);
                     @(negedge clk);
                     bus.res_ready = 1'b0;
                     totalCnt++;
                     if (bus.res_valid !== 1'b0)
                        $display("FAIL b2b_single a=%0d b=%0d bin=%0d: got rv=%b after handoff, required 0", a, b, c, bus.res_valid);
                     else passCnt++;
                     done = 1'b1;
                  end else begin
                     bus.res_ready = bus.res_valid ? 1'b0 : 1'($urandom_range(0, 1));
                     @(negedge clk);
                     n++;
                  end
               end
               if (!done) begin
                  totalCnt++;
                  $display("FAIL b2b_timeout a=%0d b=%0d bin=%0d: no result, required one", a, b, c);
               end
            end
         end
      end
      totalCnt++;
      if (results !== accepted || expQ.size() != 0)
         $display("FAIL result_count: got %0d results (%0d pending), required %0d", results, expQ.size(), accepted);
      else passCnt++;
   endtask

   initial begin
      bus.start_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.bin = 1'b0;
      bus.res_ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_reset_midrun();
      test_back_to_back();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
